// File: rtl/comp_div_if.sv
// rtl/comp_div_if.sv - start/done handshake and operand/result bus of the sequential divider
interface comp_div_if #(
    parameter int WIDTH = 32
);
    logic             run;
    logic [WIDTH-1:0] Dividend_in;
    logic [WIDTH-1:0] Divisor_in;
    logic             busy;
    logic             ready;
    logic             div_zero;
    logic [WIDTH-1:0] Quotient_out;
    logic [WIDTH-1:0] Remainder_out;

    modport master (
        output run, Dividend_in, Divisor_in,
        input  busy, ready, div_zero, Quotient_out, Remainder_out
    );

    modport slave (
        input  run, Dividend_in, Divisor_in,
        output busy, ready, div_zero, Quotient_out, Remainder_out
    );
endinterface

// File: rtl/comp_div.sv
// rtl/comp_div.sv - unsigned sequential restoring divider, one quotient bit per cycle
module comp_div #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    comp_div_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [2*WIDTH-1:0] rq;
    logic [WIDTH-1:0]   d;
    logic [CNT_W-1:0]   cnt;
    logic               busy_r;
    logic               ready_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   quotient_r;
    logic [WIDTH-1:0]   remainder_r;

    logic [WIDTH+1:0]   diff;
    logic               take;
    logic [2*WIDTH-1:0] rq_next;

    // The shifted partial remainder is WIDTH+1 bits wide so divisors above 2^(W-1) cannot overflow.
    assign diff = {1'b0, rq[2*WIDTH-1:WIDTH-1]} - {2'b00, d};
    // A successful subtract always leaves a result below d, so bit WIDTH is zero as well.
    assign take = ~diff[WIDTH+1] & ~diff[WIDTH];

    always_comb begin
        rq_next = {rq[2*WIDTH-2:0], 1'b0};
        if (take) begin
            rq_next = {diff[WIDTH-1:0], rq[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            rq          <= '0;
            d           <= '0;
            cnt         <= '0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b0;
            div_zero_r  <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.run) begin
                        if (bus.Divisor_in == '0) begin
                            state       <= S_DONE;
                            quotient_r  <= '1;
                            remainder_r <= bus.Dividend_in;
                            div_zero_r  <= 1'b1;
                            ready_r     <= 1'b1;
                            busy_r      <= 1'b0;
                        end else begin
                            state      <= S_CALC;
                            rq         <= {{WIDTH{1'b0}}, bus.Dividend_in};
                            d          <= bus.Divisor_in;
                            cnt        <= '0;
                            busy_r     <= 1'b1;
                            ready_r    <= 1'b0;
                            div_zero_r <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    rq  <= rq_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state       <= S_DONE;
                        quotient_r  <= rq_next[WIDTH-1:0];
                        remainder_r <= rq_next[2*WIDTH-1:WIDTH];
                        ready_r     <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_r;
    assign bus.ready         = ready_r;
    assign bus.div_zero      = div_zero_r;
    assign bus.Quotient_out  = quotient_r;
    assign bus.Remainder_out = remainder_r;
endmodule
